ks_tl_monitor: RTL
==================

# ks_tl_monitor

Safety monitor at the receiving end of the `ks_tl` 10-bit `lights` bus. It decodes each sampled light pattern into one of the six legal phases and checks that phases follow the fixed sequence P1→P6→P1. It measures every phase's dwell time in clock cycles against configured windows. Lamp drivers take their outputs from `safe_lights`: it carries the lights while the bus is healthy and forces all-red on a sticky fault.

## Interface
Parameters:
- `D1`, default 700000000: P1 dwell parameter. Expected dwell is `D1+1` cycles.
- `D2`, default 200000000: P2, P4 and P6 dwell parameter. Expected dwell is `D2+1` cycles.
- `D3`, default 500000000: P3 dwell parameter. Expected dwell is `D3+1` cycles.
- `D5`, default 300000000: P5 dwell parameter. Expected dwell is `D5+1` cycles.
- `TOL`, default 0: allowed ± slack, in cycles, on every dwell.
- `BLINK_CYC`, default 50000000: half-period of the fault blink, in cycles.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `lights_in`, input, 10: observed lights. [9:7] M1 {R,Y,G}, [6:4] M2 {R,Y,G}, [3:1] S {R,Y,G}, [0] MT green.
- `fault_clr`, input, 1: single-cycle pulse that clears a latched fault.
- `phase`, output, 3: index of the current phase, 0–5 for P1–P6.
- `phase_valid`, output, 1: high while in TRACK.
- `dwell`, output, 32: cycle count of the current phase. Saturates at 2^32−1.
- `fault`, output, 1: sticky fault flag.
- `fault_code`, output, 3: cause of the first fault.
- `safe_lights`, output, 10: gated lamp drive.

## Operation
Legal patterns, with M1/M2/S written as {R,Y,G}:
- P1 = 001_001_100_1
- P2 = 001_010_100_1
- P3 = 001_100_100_0
- P4 = 010_100_100_0
- P5 = 100_100_001_0
- P6 = 100_100_010_0
- All-red is defined as `ALL_RED` = 100_100_100_0.

The FSM has three states: ACQUIRE, TRACK and FAULT.

- **ACQUIRE** (entered after reset or after a clear):
  - A legal sample moves the FSM to TRACK, sets `phase` to that sample's phase and sets `dwell=1`.
  - This first phase is partial, so no short-dwell check is applied when it ends. The long-dwell check does apply.
  - An illegal sample moves the FSM to FAULT with code 1.
- **TRACK**, same pattern as the current phase: `dwell` increments.
  - If `dwell` would exceed `Dk+1+TOL`, the FSM moves to FAULT with code 4.
- **TRACK**, pattern changed:
  - An illegal pattern gives code 1.
  - A legal pattern that is not the next phase gives code 2.
  - A legal next phase with an old `dwell < Dk+1−TOL` gives code 3. The check is skipped for the first phase after ACQUIRE.
  - Otherwise `phase` advances and `dwell` resets to 1.
- **Fault priority**, when several apply in one cycle: 1 > 2 > 3. Code 4 is evaluated only on no-change cycles.
- **FAULT** is sticky:
  - `phase_valid=0` and `dwell` freezes.
  - `fault_code` holds the first cause.
  - `lights_in` is ignored.
- **`fault_clr`**, in any state: `fault=0`, `fault_code=0`, `phase_valid=0`, `dwell=0`, and the FSM returns to ACQUIRE. The sample present in that cycle is discarded.
- **Fault codes:** 0 none, 1 ILLEGAL_PATTERN, 2 ILLEGAL_TRANSITION, 3 DWELL_SHORT, 4 DWELL_LONG. Codes 5–7 are reserved.
- **`safe_lights`:**
  - In TRACK it is the registered `lights_in`.
  - In ACQUIRE it is `ALL_RED`, except for a legal sample, which is passed through.
  - In FAULT it follows the blink feature (see Configuration).
  - An offending sample is never passed through.

## Timing
- Every output is registered. A sample presented before edge N is reflected in all outputs after edge N (1-cycle latency).
- A fault asserts on the same edge that captures the offending sample. `safe_lights` becomes `ALL_RED` on that same edge.
- Reset values:
  - `phase=0`, `phase_valid=0`, `dwell=0`, `fault=0`, `fault_code=0`.
  - `safe_lights=ALL_RED`.
  - FSM in ACQUIRE, blink counter 0, blink phase on.
- Priority: `rst` > `fault_clr` > fault detection. Asserting `rst` mid-phase or mid-fault fully restarts the monitor.
- Dwell semantics: a phase held for exactly `Dk+1` cycles, with TOL=0, passes.
- The blink counter runs only in FAULT. It wraps at `BLINK_CYC−1` and toggles the blink phase on wrap. It restarts at 0, in the on phase, whenever FAULT is entered.

## Configuration
- `KS_TL_MON_BLINK_EN` defined: in FAULT, `safe_lights` alternates between `ALL_RED` and `10'b0`, `BLINK_CYC` cycles each, starting with `ALL_RED`.
- Macro undefined: in FAULT, `safe_lights` is held at steady `ALL_RED`, and no blink counter is synthesised.

## Structure
- Package `ks_tl_pkg` holds:
  - the six phase patterns and `ALL_RED`;
  - the phase index type (3 bits);
  - the fault code constants;
  - the monitor state enum.
- `ks_tl` shares the package.
- Sub-module `ks_tl_phase_decode`: a combinational decoder from `lights_in` to {`legal`, `phase_idx`}. Its second function maps a phase index to its dwell parameter.

## Test plan
Parameter overrides for all tests: D1=7, D2=2, D3=5, D5=3, TOL=0, BLINK_CYC=4.
- **Healthy cycle.** Drive P1×8, P2×3, P3×6, P4×3, P5×4, P6×3, for two full rounds. Expect `fault=0` throughout, `phase` stepping 0→5→0, and `safe_lights` equal to the input delayed by 1 cycle.
- **Short dwell.** After one healthy round, hold P1 for 5 cycles, then drive P2. Expect `fault=1` and `fault_code=3` on the edge capturing P2, and `safe_lights=ALL_RED` on that edge.
- **Long dwell.** Hold P3 for 7 cycles. Expect `fault_code=4` on the 7th P3 edge.
- **Illegal pattern and transition.**
  - Drive 001_001_001_1 mid-P1. Expect `fault_code=1`.
  - Separately, drive P1 followed directly by P3. Expect `fault_code=2`.
- **Clear and re-acquire.** From FAULT, pulse `fault_clr`, then drive P4×2 (partial), P5×4. Expect no fault, `phase_valid=1` from the first P4 edge, and `phase=4` after P5.
- **Blink and reset.** With `KS_TL_MON_BLINK_EN` defined:
  - In FAULT, expect `safe_lights` toggling between `ALL_RED` and 0 every 4 cycles.
  - Assert `rst` for one cycle. Expect all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/ks_tl_pkg.sv
// ks_tl_pkg: shared constants and types for the ks_tl traffic-light
// controller and its receiving-end safety monitor.
// Holds the six legal phase patterns, ALL_RED, the phase index type,
// the monitor fault codes and the monitor state enum.
package ks_tl_pkg;

  // Light bus layout: [9:7] M1 {R,Y,G}, [6:4] M2 {R,Y,G}, [3:1] S {R,Y,G}, [0] MT green
  localparam logic [9:0] P1_PAT     = 10'b001_001_100_1;
  localparam logic [9:0] P2_PAT     = 10'b001_010_100_1;
  localparam logic [9:0] P3_PAT     = 10'b001_100_100_0;
  localparam logic [9:0] P4_PAT     = 10'b010_100_100_0;
  localparam logic [9:0] P5_PAT     = 10'b100_100_001_0;
  localparam logic [9:0] P6_PAT     = 10'b100_100_010_0;
  localparam logic [9:0] ALL_RED    = 10'b100_100_100_0;
  localparam logic [9:0] LIGHTS_OFF = 10'b000_000_000_0;

  // Phase index: 0..5 for P1..P6
  typedef logic [2:0] phase_t;

  localparam phase_t PHASE_LAST = 3'd5;

  // Fault causes; 5..7 are reserved
  localparam logic [2:0] FC_NONE               = 3'd0;
  localparam logic [2:0] FC_ILLEGAL_PATTERN    = 3'd1;
  localparam logic [2:0] FC_ILLEGAL_TRANSITION = 3'd2;
  localparam logic [2:0] FC_DWELL_SHORT        = 3'd3;
  localparam logic [2:0] FC_DWELL_LONG         = 3'd4;

  typedef enum logic [1:0] {
    MON_ACQUIRE = 2'd0,
    MON_TRACK   = 2'd1,
    MON_FAULT   = 2'd2
  } mon_state_t;

  // Successor phase in the fixed P1 -> P6 -> P1 ring
  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    if (p >= PHASE_LAST) begin
      n = 3'd0;
    end else begin
      n = p + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ks_tl_phase_decode.sv
// ks_tl_phase_decode: combinational lookup for the monitor.
// Decodes a light sample into {legal, phase_idx} and maps the currently
// tracked phase index to its dwell parameter Dk (expected dwell is Dk+1).
module ks_tl_phase_decode
  import ks_tl_pkg::*;
#(
  parameter int unsigned D1 = 32'd700000000,
  parameter int unsigned D2 = 32'd200000000,
  parameter int unsigned D3 = 32'd500000000,
  parameter int unsigned D5 = 32'd300000000
) (
  input  logic [9:0]  lights,
  input  phase_t      cur_phase,
  output logic        legal,
  output phase_t      phase_idx,
  output logic [31:0] dk
);

  // Pattern to phase decode; anything outside the six patterns is illegal
  always_comb begin
    legal     = 1'b1;
    phase_idx = 3'd0;
    case (lights)
      P1_PAT:  phase_idx = 3'd0;
      P2_PAT:  phase_idx = 3'd1;
      P3_PAT:  phase_idx = 3'd2;
      P4_PAT:  phase_idx = 3'd3;
      P5_PAT:  phase_idx = 3'd4;
      P6_PAT:  phase_idx = 3'd5;
      default: begin
        legal     = 1'b0;
        phase_idx = 3'd0;
      end
    endcase
  end

  // Dwell parameter of the phase being tracked; P2/P4/P6 share D2
  always_comb begin
    dk = D2;
    case (cur_phase)
      3'd0:    dk = D1;
      3'd1:    dk = D2;
      3'd2:    dk = D3;
      3'd3:    dk = D2;
      3'd4:    dk = D5;
      3'd5:    dk = D2;
      default: dk = D2;
    endcase
  end

endmodule

// File: rtl/ks_tl_monitor.sv
// ks_tl_monitor: receiving-end safety monitor for the ks_tl lights bus.
// Tracks the P1..P6 phase ring, checks per-phase dwell windows and gates
// the lamp drive to ALL_RED on a sticky fault.
// Optional feature: define KS_TL_MON_BLINK_EN to blink ALL_RED / off in
// FAULT (BLINK_CYC cycles each); otherwise FAULT holds steady ALL_RED.
module ks_tl_monitor
  import ks_tl_pkg::*;
#(
  parameter int unsigned D1        = 32'd700000000,
  parameter int unsigned D2        = 32'd200000000,
  parameter int unsigned D3        = 32'd500000000,
  parameter int unsigned D5        = 32'd300000000,
  parameter int unsigned TOL       = 32'd0,
  parameter int unsigned BLINK_CYC = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  lights_in,
  input  logic        fault_clr,
  output logic [2:0]  phase,
  output logic        phase_valid,
  output logic [31:0] dwell,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [9:0]  safe_lights
);

  localparam logic [31:0] DWELL_MAX = 32'hFFFF_FFFF;

  mon_state_t  state_r, state_s;
  phase_t      phase_r, phase_s;
  logic        phase_valid_r;
  logic [31:0] dwell_r, dwell_s;
  logic        fault_r, fault_s;
  logic [2:0]  code_r, code_s;
  logic [9:0]  safe_lights_r, safe_s;
  logic        first_r, first_s;

  logic        legal_s;
  phase_t      idx_s;
  logic [31:0] dk_s;
  logic        hit_s;
  logic [2:0]  hit_code_s;
  logic [33:0] dwell_x_s;
  logic [33:0] tol_x_s;
  logic [33:0] dk_x_s;
  logic        too_long_s;
  logic        too_short_s;

  ks_tl_phase_decode #(
    .D1 (D1),
    .D2 (D2),
    .D3 (D3),
    .D5 (D5)
  ) u_decode (
    .lights    (lights_in),
    .cur_phase (phase_r),
    .legal     (legal_s),
    .phase_idx (idx_s),
    .dk        (dk_s)
  );

  // Dwell window comparisons, widened so Dk+1+TOL and Dk+1-TOL cannot wrap
  always_comb begin
    dwell_x_s   = {2'b00, dwell_r};
    tol_x_s     = {2'b00, TOL};
    dk_x_s      = {2'b00, dk_s};
    // dwell+1 > Dk+1+TOL  <=>  dwell > Dk+TOL
    too_long_s  = (dwell_x_s > (dk_x_s + tol_x_s));
    // dwell < Dk+1-TOL  <=>  dwell+TOL < Dk+1
    too_short_s = ((dwell_x_s + tol_x_s) < (dk_x_s + 34'd1));
  end

`ifdef KS_TL_MON_BLINK_EN
  logic [31:0] blink_cnt_r, blink_cnt_s;
  logic        blink_on_r, blink_on_s;

  // Blink timebase: free-runs while staying in FAULT, parked at 0/on otherwise
  always_comb begin
    blink_cnt_s = 32'd0;
    blink_on_s  = 1'b1;
    if ((state_r == MON_FAULT) && !fault_clr) begin
      if (blink_cnt_r >= (BLINK_CYC - 32'd1)) begin
        blink_cnt_s = 32'd0;
        blink_on_s  = ~blink_on_r;
      end else begin
        blink_cnt_s = blink_cnt_r + 32'd1;
        blink_on_s  = blink_on_r;
      end
    end else begin
      blink_cnt_s = 32'd0;
      blink_on_s  = 1'b1;
    end
  end

  // Blink timebase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= 32'd0;
      blink_on_r  <= 1'b1;
    end else begin
      blink_cnt_r <= blink_cnt_s;
      blink_on_r  <= blink_on_s;
    end
  end
`endif

  // Monitor next-state: clear beats detection; faults force ALL_RED at once
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r;
    dwell_s    = dwell_r;
    fault_s    = fault_r;
    code_s     = code_r;
    first_s    = first_r;
    safe_s     = safe_lights_r;
    hit_s      = 1'b0;
    hit_code_s = FC_NONE;
    if (fault_clr) begin
      state_s = MON_ACQUIRE;
      dwell_s = 32'd0;
      fault_s = 1'b0;
      code_s  = FC_NONE;
      first_s = 1'b0;
      safe_s  = ALL_RED;
    end else begin
      case (state_r)
        MON_ACQUIRE: begin
          if (legal_s) begin
            state_s = MON_TRACK;
            phase_s = idx_s;
            dwell_s = 32'd1;
            first_s = 1'b1;
            safe_s  = lights_in;
          end else begin
            hit_s      = 1'b1;
            hit_code_s = FC_ILLEGAL_PATTERN;
          end
        end
        MON_TRACK: begin
          if (legal_s && (idx_s == phase_r)) begin
            if (too_long_s) begin
              hit_s      = 1'b1;
              hit_code_s = FC_DWELL_LONG;
            end else begin
              dwell_s = (dwell_r == DWELL_MAX) ? dwell_r : (dwell_r + 32'd1);
              safe_s  = lights_in;
            end
          end else if (!legal_s) begin
            hit_s      = 1'b1;
            hit_code_s = FC_ILLEGAL_PATTERN;
          end else if (idx_s != next_phase(phase_r)) begin
            hit_s      = 1'b1;
            hit_code_s = FC_ILLEGAL_TRANSITION;
          end else if (!first_r && too_short_s) begin
            hit_s      = 1'b1;
            hit_code_s = FC_DWELL_SHORT;
          end else begin
            phase_s = idx_s;
            dwell_s = 32'd1;
            first_s = 1'b0;
            safe_s  = lights_in;
          end
        end
        MON_FAULT: begin
`ifdef KS_TL_MON_BLINK_EN
          safe_s = blink_on_s ? ALL_RED : LIGHTS_OFF;
`else
          safe_s = ALL_RED;
`endif
        end
        default: begin
          // Unreachable encoding: fail safe without inventing a cause
          state_s = MON_FAULT;
          fault_s = 1'b1;
          safe_s  = ALL_RED;
        end
      endcase
      if (hit_s) begin
        state_s = MON_FAULT;
        fault_s = 1'b1;
        code_s  = hit_code_s;
        safe_s  = ALL_RED;
      end else begin
        state_s = state_s;
      end
    end
  end

  // Monitor state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= MON_ACQUIRE;
      phase_r       <= 3'd0;
      phase_valid_r <= 1'b0;
      dwell_r       <= 32'd0;
      fault_r       <= 1'b0;
      code_r        <= FC_NONE;
      first_r       <= 1'b0;
      safe_lights_r <= ALL_RED;
    end else begin
      state_r       <= state_s;
      phase_r       <= phase_s;
      phase_valid_r <= (state_s == MON_TRACK);
      dwell_r       <= dwell_s;
      fault_r       <= fault_s;
      code_r        <= code_s;
      first_r       <= first_s;
      safe_lights_r <= safe_s;
    end
  end

  assign phase       = phase_r;
  assign phase_valid = phase_valid_r;
  assign dwell       = dwell_r;
  assign fault       = fault_r;
  assign fault_code  = code_r;
  assign safe_lights = safe_lights_r;

endmodule
